// File: rtl/shift_serdes_if.sv
// Load/shift handshake and serial/parallel data bundle for shift_serdes.
// Master is the controller side; slave is the shift engine.
interface shift_serdes_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  shift_en;
  logic                  serial_in;
  logic                  serial_out;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_out;
  logic [CNT_WIDTH-1:0]  bit_count;
  logic                  parity_err;

  modport master (
    output load_valid, data_in, shift_en, serial_in,
    input  load_ready, serial_out, busy, done, data_out, bit_count, parity_err
  );

  modport slave (
    input  load_valid, data_in, shift_en, serial_in,
    output load_ready, serial_out, busy, done, data_out, bit_count, parity_err
  );
endinterface

// File: rtl/shift_serdes.sv
// Parallel-load shift engine: transmits a word on serial_out while capturing serial_in.
// Optional even-parity bit enabled by defining SHIFT_PARITY_EN.
module shift_serdes #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  shift_serdes_if.slave   bus
);

`ifdef SHIFT_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  bit_count_q, bit_count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  emit_bit;

  // Concatenate-then-truncate keeps the shift legal for DATA_WIDTH == 1.
  if (MSB_FIRST) begin : g_msb
    assign shifted  = DATA_WIDTH'({shreg_q, bus.serial_in});
    assign emit_bit = shreg_q[DATA_WIDTH-1];
  end else begin : g_lsb
    assign shifted  = DATA_WIDTH'({bus.serial_in, shreg_q} >> 1);
    assign emit_bit = shreg_q[0];
  end

`ifdef SHIFT_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    data_out_d  = data_out_q;
`ifdef SHIFT_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          shreg_d     = bus.data_in;
          bit_count_d = '0;
          state_d     = SHIFT;
`ifdef SHIFT_PARITY_EN
          par_d        = ^bus.data_in;
          parity_err_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          shreg_d     = shifted;
          bit_count_d = bit_count_q + CNT_WIDTH'(1);
          if (bit_count_q == LAST_CNT) begin
`ifdef SHIFT_PARITY_EN
            state_d = PARITY;
`else
            state_d    = DONE;
            data_out_d = shifted;
`endif
          end
        end
      end
`ifdef SHIFT_PARITY_EN
      // The received word stays parked in shreg_q while the parity bit goes out.
      PARITY: begin
        if (bus.shift_en) begin
          parity_err_d = bus.serial_in != (^shreg_q);
          data_out_d   = shreg_q;
          state_d      = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All state moves on the falling edge; reset is sampled there too.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_count_q <= '0;
      data_out_q  <= '0;
`ifdef SHIFT_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      data_out_q  <= data_out_d;
`ifdef SHIFT_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.data_out   = data_out_q;
  assign bus.bit_count  = bit_count_q;

`ifdef SHIFT_PARITY_EN
  assign bus.busy       = (state_q == SHIFT) || (state_q == PARITY);
  assign bus.serial_out = (state_q == PARITY) ? par_q : emit_bit;
  assign bus.parity_err = parity_err_q;
`else
  assign bus.busy       = (state_q == SHIFT);
  assign bus.serial_out = emit_bit;
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_serdes.sv
// Self-checking bench for shift_serdes: MSB-first, LSB-first and one-bit instances
// against a word-level model of what goes out and what comes back.
module tb_shift_serdes;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  shift_serdes_if #(.DATA_WIDTH(8)) if_m ();
  shift_serdes_if #(.DATA_WIDTH(8)) if_l ();
  shift_serdes_if #(.DATA_WIDTH(1)) if_1 ();

  shift_serdes #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_m));
  shift_serdes #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_l));
  shift_serdes #(.DATA_WIDTH(1), .MSB_FIRST(1'b1)) u_w1  (.clk(clk), .reset(reset), .bus(if_1));

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       so;
    logic       perr;
    logic [7:0] dout;
    logic [3:0] cnt;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t snap(input int sel);
    obs_t o;
    if (sel == 0) o = '{if_m.load_ready, if_m.busy, if_m.done, if_m.serial_out,
                        if_m.parity_err, if_m.data_out, if_m.bit_count};
    else          o = '{if_l.load_ready, if_l.busy, if_l.done, if_l.serial_out,
                        if_l.parity_err, if_l.data_out, if_l.bit_count};
    return o;
  endfunction

  task automatic drive(input int sel, input logic lv, input logic [7:0] d,
                       input logic en, input logic si);
    if (sel == 0) begin
      if_m.load_valid = lv; if_m.data_in = d; if_m.shift_en = en; if_m.serial_in = si;
    end else begin
      if_l.load_valid = lv; if_l.data_in = d; if_l.shift_en = en; if_l.serial_in = si;
    end
  endtask

  // mode: 0 = loopback, 1 = serial_in held 1, 2 = random serial_in.
  task automatic transfer(input int sel, input logic [7:0] data, input int mode,
                          input bit toggle_en, input bit noise, input bit bad_par);
    obs_t       o;
    logic [7:0] r_bits;
    logic [7:0] exp_word;
    logic       sent, sin, en, exp_perr;
    int         i, edges;

    o = snap(sel);
    check("ready_idle", 32'(o.ready), 1);
    drive(sel, 1'b1, data, 1'b0, 1'b0);
    @(posedge clk);
    o = snap(sel);
    check("busy_after_load", 32'(o.busy), 1);
    check("cnt_after_load", 32'(o.cnt), 0);

    i = 0; edges = 0; en = 1'b1; r_bits = '0;
    while (i < 8 && edges < 40) begin
      o    = snap(sel);
      sent = (sel == 0) ? data[7-i] : data[i];
      check("serial_out_bit", 32'(o.so), 32'(sent));
      check("busy_shift", 32'(o.busy), 1);
      en  = toggle_en ? ~en : 1'b1;
      sin = (mode == 0) ? o.so : (mode == 1) ? 1'b1 : 1'($urandom);
      drive(sel, noise ? 1'($urandom) : 1'b0, 8'($urandom), en, sin);
      @(posedge clk);
      edges++;
      if (en) begin
        r_bits[i] = sin;
        i++;
      end
      o = snap(sel);
      check("bit_count_step", 32'(o.cnt), 32'(i));
    end
    check("edges_to_end", 32'(edges), toggle_en ? 16 : 8);

    for (int k = 0; k < 8; k++) begin
      if (sel == 0) exp_word[7-k] = r_bits[k];
      else          exp_word[k]   = r_bits[k];
    end

`ifdef SHIFT_PARITY_EN
    o = snap(sel);
    check("parity_out", 32'(o.so), 32'(^data));
    check("busy_parity", 32'(o.busy), 1);
    check("cnt_parity", 32'(o.cnt), 8);
    sin = bad_par ? 1'b0 : (mode == 0) ? o.so : 1'($urandom);
    exp_perr = (sin != ^exp_word);
    drive(sel, 1'b0, 8'h00, 1'b1, sin);
    @(posedge clk);
`else
    exp_perr = 1'b0;
    if (bad_par) exp_perr = 1'b0;
`endif

    o = snap(sel);
    check("done_pulse", 32'(o.done), 1);
    check("busy_done", 32'(o.busy), 0);
    check("ready_done", 32'(o.ready), 0);
    check("data_out", 32'(o.dout), 32'(exp_word));
    check("cnt_done", 32'(o.cnt), 8);
    check("parity_err", 32'(o.perr), 32'(exp_perr));
    drive(sel, noise ? 1'b1 : 1'b0, 8'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    o = snap(sel);
    check("ready_back", 32'(o.ready), 1);
    check("done_clear", 32'(o.done), 0);
    check("busy_back", 32'(o.busy), 0);
    check("cnt_hold", 32'(o.cnt), 8);
    drive(sel, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    obs_t o;
    reset = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    if_1.load_valid = 1'b0; if_1.data_in = 1'b0; if_1.shift_en = 1'b0; if_1.serial_in = 1'b0;
    repeat (2) @(posedge clk);

    for (int s = 0; s < 2; s++) begin
      o = snap(s);
      check("rst_ready", 32'(o.ready), 1);
      check("rst_busy", 32'(o.busy), 0);
      check("rst_done", 32'(o.done), 0);
      check("rst_serial_out", 32'(o.so), 0);
      check("rst_data_out", 32'(o.dout), 0);
      check("rst_cnt", 32'(o.cnt), 0);
      check("rst_perr", 32'(o.perr), 0);
    end
    reset = 1'b1;

    // Directed transfers from the reference scenarios.
    transfer(0, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    transfer(1, 8'h01, 1, 1'b0, 1'b0, 1'b0);
    transfer(0, 8'h5A, 0, 1'b1, 1'b1, 1'b0);
    transfer(1, 8'hC3, 2, 1'b1, 1'b1, 1'b0);

    // Reset after three shifts aborts the transfer.
    drive(0, 1'b1, 8'h96, 1'b0, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk);
    end
    reset = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    o = snap(0);
    check("abort_ready", 32'(o.ready), 1);
    check("abort_busy", 32'(o.busy), 0);
    check("abort_cnt", 32'(o.cnt), 0);
    check("abort_data_out", 32'(o.dout), 0);
    check("abort_q_zero", 32'(o.so), 0);
    transfer(0, 8'h3C, 0, 1'b0, 1'b0, 1'b0);

`ifdef SHIFT_PARITY_EN
    transfer(0, 8'h07, 0, 1'b0, 1'b0, 1'b0);
    transfer(0, 8'h07, 0, 1'b0, 1'b0, 1'b1);
`endif

    for (int t = 0; t < 6; t++)
      transfer(int'($urandom_range(1, 0)), 8'($urandom), int'($urandom_range(2, 0)),
               1'($urandom), 1'($urandom), 1'b0);

    // One-bit word.
    check("w1_ready", 32'(if_1.load_ready), 1);
    if_1.load_valid = 1'b1; if_1.data_in = 1'b1;
    @(posedge clk);
    if_1.load_valid = 1'b0;
    check("w1_serial_out", 32'(if_1.serial_out), 1);
    check("w1_busy", 32'(if_1.busy), 1);
    if_1.shift_en = 1'b1; if_1.serial_in = 1'b0;
    @(posedge clk);
`ifdef SHIFT_PARITY_EN
    check("w1_parity_out", 32'(if_1.serial_out), 1);
    if_1.serial_in = if_1.serial_out;
    @(posedge clk);
`endif
    if_1.shift_en = 1'b0;
    check("w1_done", 32'(if_1.done), 1);
    check("w1_data_out", 32'(if_1.data_out), 0);
    check("w1_cnt", 32'(if_1.bit_count), 1);
    @(posedge clk);
    check("w1_ready_back", 32'(if_1.load_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
